// File: rtl/bh_encoder_4to2_reg_pkg.sv
// Shared definitions for the registered one-hot encoder.
//   IN_W / OUT_W / CNT_W : default widths (one-hot input, code, error counter)
//   state_t              : two-state holding FSM (ST_EMPTY / ST_FULL)
//   ERR_MAX              : saturation value of an error counter of default width
package enc_pkg;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

endpackage : enc_pkg

// File: rtl/bh_encoder_4to2_reg_prio_encoder.sv
// Combinational priority encoder.
//   in     : input word
//   code   : index of the highest set bit (0 when in == 0)
//   onehot : 1 when exactly one bit of in is set
module bh_prio_encoder #(
    parameter int IN_W  = enc_pkg::IN_W,
    parameter int OUT_W = enc_pkg::OUT_W
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] code,
    output logic             onehot
);

    localparam int ONES_W = $clog2(IN_W + 1);

    logic [ONES_W-1:0] ones;

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        code = '0;
        ones = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (in[i]) begin
                code = OUT_W'(i);
                ones = ones + 1'b1;
            end
        end
        onehot = (ones == ONES_W'(1));
    end

endmodule : bh_prio_encoder

// File: rtl/bh_encoder_4to2_reg.sv
// Registered one-hot to binary encoder with a valid/ready handshake.
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in: input channel carrying the one-hot word
//   out_valid/out_ready : output channel; out is the encoded index and
//                         out_err flags a held word that was not one-hot
//   err_cnt / err_clr   : saturating count of accepted non-one-hot words,
//                         synchronously cleared by err_clr
//
// Handshake: a transfer happens on a channel in any cycle where both its
// valid and ready are high at the rising clock edge. The producer keeps
// valid (and data) asserted until the transfer; the only combinational
// path is out_ready -> in_ready, which lets a full register be refilled in
// the same cycle it is drained (one word per cycle).
//
// The FSM state is directly visible as out_valid (FULL <=> out_valid).
module bh_encoder_4to2_reg #(
    parameter int IN_W  = enc_pkg::IN_W,
    parameter int OUT_W = enc_pkg::OUT_W,
    parameter int CNT_W = enc_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    import enc_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [OUT_W-1:0] enc_code;
    logic             enc_onehot;
    logic             in_xfer;

    bh_prio_encoder #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_prio (
        .in     (in),
        .code   (enc_code),
        .onehot (enc_onehot)
    );

    assign in_ready  = (state == ST_EMPTY) | out_ready;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = (state == ST_FULL);

    // Holding FSM and output register. The register only loads on an input
    // transfer, so out/out_err stay frozen while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_EMPTY;
            out     <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state   <= ST_FULL;
                        out     <= enc_code;
                        out_err <= ~enc_onehot;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            out     <= enc_code;
                            out_err <= ~enc_onehot;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Error counter: clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (in_xfer && !enc_onehot && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule : bh_encoder_4to2_reg
